// File: rtl/dmem_if.sv
// CPU data-port bundle between the core (master) and the data-memory responder (slave).
// Also carries the responder's status outputs.
interface dmem_if;
   logic        memwrite;
   logic        memread;
   logic [31:0] dataadr;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        ready;
   logic        misaligned_err;
   logic        done;
   logic        pass;
   logic [15:0] writecount;

   modport master (
      output memwrite, memread, dataadr, writedata,
      input  readdata, ready, misaligned_err, done, pass, writecount
   );

   modport slave (
      input  memwrite, memread, dataadr, writedata,
      output readdata, ready, misaligned_err, done, pass, writecount
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM behind a fixed wait-state handshake, with a
// saturating write counter and pass/fail signature-store detection.
module dmem_responder #(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [31:0] SIG_ADR     = 32'h0000_0054,
   parameter logic [31:0] SIG_DATA    = 32'h0000_0007
) (
   input  logic   clk,
   input  logic   reset,
   dmem_if.slave  bus
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam logic [3:0] WAIT_LAST = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t      state_q,      state_d;
   logic [3:0]  cnt_q,        cnt_d;
   logic [31:0] adr_q,        adr_d;
   logic [31:0] wdata_q,      wdata_d;
   logic        is_write_q,   is_write_d;
   logic [31:0] readdata_q,   readdata_d;
   logic        misaligned_q, misaligned_d;
   logic        done_q,       done_d;
   logic        pass_q,       pass_d;
   logic [15:0] wcount_q,     wcount_d;

   logic [31:0]       ram [DEPTH];
   logic [ADDR_W-1:0] idx;
   logic              acc_misaligned;
   logic [31:0]       rd_val;

   assign idx            = adr_q[ADDR_W+1:2];
   assign acc_misaligned = (adr_q[1:0] != 2'b00);
   assign rd_val         = acc_misaligned ? 32'h0 : ram[idx];

   always_comb begin
      // NOTE: every next-state signal defaults to its current value first, so no path infers a latch.
      state_d      = state_q;
      cnt_d        = cnt_q;
      adr_d        = adr_q;
      wdata_d      = wdata_q;
      is_write_d   = is_write_q;
      readdata_d   = readdata_q;
      misaligned_d = misaligned_q;
      done_d       = done_q;
      pass_d       = pass_q;
      wcount_d     = wcount_q;

      case (state_q)
         S_IDLE: begin
            if (bus.memwrite || bus.memread) begin
               adr_d      = bus.dataadr;
               wdata_d    = bus.writedata;
               is_write_d = bus.memwrite;
               cnt_d      = 4'd0;
               state_d    = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == WAIT_LAST) state_d = S_RESP;
            else                    cnt_d   = cnt_q + 4'd1;
         end
         S_RESP: begin
            state_d = S_IDLE;
            if (acc_misaligned) begin
               misaligned_d = 1'b1;
               if (!is_write_q) readdata_d = 32'h0;
            end else if (is_write_q) begin
               if (wcount_q != 16'hFFFF) wcount_d = wcount_q + 16'd1;
               // Only the first store to the exact signature address decides the verdict.
               if (adr_q == SIG_ADR && !done_q) begin
                  done_d = 1'b1;
                  pass_d = (wdata_q == SIG_DATA);
               end
            end else begin
               readdata_d = rd_val;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= 4'd0;
         adr_q        <= 32'h0;
         wdata_q      <= 32'h0;
         is_write_q   <= 1'b0;
         readdata_q   <= 32'h0;
         misaligned_q <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         wcount_q     <= 16'h0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         adr_q        <= adr_d;
         wdata_q      <= wdata_d;
         is_write_q   <= is_write_d;
         readdata_q   <= readdata_d;
         misaligned_q <= misaligned_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         wcount_q     <= wcount_d;
      end
   end

   // NOTE: the RAM array has no reset; reset only gates the write so an abandoned transaction never commits.
   always_ff @(posedge clk) begin
      if (reset && state_q == S_RESP && is_write_q && !acc_misaligned)
         ram[idx] <= wdata_q;
   end

   assign bus.ready          = (state_q == S_RESP);
   assign bus.readdata       = (state_q == S_RESP && !is_write_q) ? rd_val : readdata_q;
   assign bus.misaligned_err = misaligned_q;
   assign bus.done           = done_q;
   assign bus.pass           = pass_q;
   assign bus.writecount     = wcount_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states for the
// functional checks, one with zero wait states for throughput and counter saturation.
module tb_dmem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset2, reset0;
   dmem_if bus2();
   dmem_if bus0();

   dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(2), .SIG_ADR(32'h54), .SIG_DATA(32'h7))
      dut2 (.clk(clk), .reset(reset2), .bus(bus2));
   dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(0), .SIG_ADR(32'h54), .SIG_DATA(32'h7))
      dut0 (.clk(clk), .reset(reset0), .bus(bus0));

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] rd;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
   endtask

   task automatic status(input string tag, input logic mis, input logic dn, input logic ps,
                         input logic [15:0] wc);
      check({tag, " misaligned_err"}, bus2.misaligned_err, mis);
      check({tag, " done"},           bus2.done,           dn);
      check({tag, " pass"},           bus2.pass,           ps);
      check({tag, " writecount"},     bus2.writecount,     wc);
   endtask

   task automatic reset_dut2();
      reset2        = 1'b0;
      bus2.memwrite = 1'b0;
      bus2.memread  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset2 = 1'b1;
   endtask

   // Starts at a falling edge; request is sampled at the next rising edge (edge 0).
   // Inputs are scrambled during WAIT to show the captured values are used.
   task automatic access(input string tag, input logic w, input logic r,
                         input logic [31:0] a, input logic [31:0] d, output logic [31:0] data);
      int lat;
      lat  = -1;
      data = 32'h0;
      bus2.memwrite  = w;
      bus2.memread   = r;
      bus2.dataadr   = a;
      bus2.writedata = d;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == 0) begin
            bus2.dataadr   = ~a;
            bus2.writedata = ~d;
         end
         if (bus2.ready) begin
            lat  = k + 1;
            data = bus2.readdata;
            break;
         end
      end
      bus2.memwrite = 1'b0;
      bus2.memread  = 1'b0;
      check({tag, " ready cycle"}, lat, 3);
      @(posedge clk);
      @(negedge clk);
      check({tag, " ready single"}, bus2.ready, 1'b0);
   endtask

   initial begin
      int seen;
      int pulses;

      reset2 = 1'b0;
      reset0 = 1'b0;
      bus2.memwrite = 1'b0; bus2.memread = 1'b0; bus2.dataadr = 32'h0; bus2.writedata = 32'h0;
      bus0.memwrite = 1'b0; bus0.memread = 1'b0; bus0.dataadr = 32'h0; bus0.writedata = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset readdata", bus2.readdata, 32'h0);
      check("reset ready",    bus2.ready,    1'b0);
      status("reset", 1'b0, 1'b0, 1'b0, 16'd0);
      check("reset0 ready",   bus0.ready,    1'b0);
      reset2 = 1'b1;

      // Basic write / read-back with two wait states.
      access("wr 0x10", 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, rd);
      status("wr 0x10", 1'b0, 1'b0, 1'b0, 16'd1);
      access("rd 0x10", 1'b0, 1'b1, 32'h10, 32'h0, rd);
      check("rd 0x10 data", rd, 32'hDEADBEEF);

      // Passing signature, then a later store that must not change the verdict.
      reset_dut2();
      access("sig 7", 1'b1, 1'b0, 32'h54, 32'd7, rd);
      status("sig 7", 1'b0, 1'b1, 1'b1, 16'd1);
      access("sig 9", 1'b1, 1'b0, 32'h54, 32'd9, rd);
      status("sig 9", 1'b0, 1'b1, 1'b1, 16'd2);
      access("rd 0x54", 1'b0, 1'b1, 32'h54, 32'h0, rd);
      check("rd 0x54 data", rd, 32'd9);

      // Alias of the signature address writes RAM[21] only; then a failing signature.
      reset_dut2();
      access("alias", 1'b1, 1'b0, 32'h1000_0054, 32'hA5A5_0F0F, rd);
      status("alias", 1'b0, 1'b0, 1'b0, 16'd1);
      access("rd alias", 1'b0, 1'b1, 32'h54, 32'h0, rd);
      check("rd alias data", rd, 32'hA5A5_0F0F);
      access("sig 21", 1'b1, 1'b0, 32'h54, 32'd21, rd);
      status("sig 21", 1'b0, 1'b1, 1'b0, 16'd2);
      access("sig 7 late", 1'b1, 1'b0, 32'h54, 32'd7, rd);
      status("sig 7 late", 1'b0, 1'b1, 1'b0, 16'd3);

      // Misaligned accesses.
      reset_dut2();
      access("wr 0x10 b", 1'b1, 1'b0, 32'h10, 32'h1111_1111, rd);
      access("wr 0x12", 1'b1, 1'b0, 32'h12, 32'h2222_2222, rd);
      status("wr 0x12", 1'b1, 1'b0, 1'b0, 16'd1);
      access("rd 0x10 b", 1'b0, 1'b1, 32'h10, 32'h0, rd);
      check("rd 0x10 b data", rd, 32'h1111_1111);
      access("rd 0x13", 1'b0, 1'b1, 32'h13, 32'h0, rd);
      check("rd 0x13 data", rd, 32'h0);
      status("rd 0x13", 1'b1, 1'b0, 1'b0, 16'd1);

      // Write has priority when both requests are high.
      reset_dut2();
      access("both 0x20", 1'b1, 1'b1, 32'h20, 32'h3333_3333, rd);
      status("both 0x20", 1'b0, 1'b0, 1'b0, 16'd1);
      access("rd 0x20", 1'b0, 1'b1, 32'h20, 32'h0, rd);
      check("rd 0x20 data", rd, 32'h3333_3333);
      access("wr 0x24", 1'b1, 1'b0, 32'h24, 32'h5555_5555, rd);

      // Reset during WAIT: nothing commits, every output clears.
      bus2.memwrite = 1'b1; bus2.dataadr = 32'h20; bus2.writedata = 32'h4444_4444;
      @(posedge clk);
      @(negedge clk);
      reset2 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rst wait ready",    bus2.ready,    1'b0);
      check("rst wait readdata", bus2.readdata, 32'h0);
      status("rst wait", 1'b0, 1'b0, 1'b0, 16'd0);
      bus2.memwrite = 1'b0;
      reset2 = 1'b1;
      access("rd 0x20 b", 1'b0, 1'b1, 32'h20, 32'h0, rd);
      check("rd 0x20 b data", rd, 32'h3333_3333);

      // Reset during RESP: the write is abandoned.
      bus2.memwrite = 1'b1; bus2.dataadr = 32'h24; bus2.writedata = 32'h6666_6666;
      seen = 0;
      for (int k = 0; k < 20 && seen == 0; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus2.ready) seen = 1;
      end
      check("rst resp reached", seen, 1);
      reset2 = 1'b0;
      bus2.memwrite = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rst resp ready", bus2.ready, 1'b0);
      check("rst resp writecount", bus2.writecount, 16'd0);
      reset2 = 1'b1;
      access("rd 0x24", 1'b0, 1'b1, 32'h24, 32'h0, rd);
      check("rd 0x24 data", rd, 32'h5555_5555);

      // Zero wait states: back-to-back writes and counter saturation.
      reset0 = 1'b1;
      bus0.memwrite = 1'b1; bus0.dataadr = 32'h8; bus0.writedata = 32'h0000_1234;
      pulses = 0;
      for (int k = 0; k < 140000 && pulses < 65540; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k < 8) check($sformatf("w0 ready cyc %0d", k), bus0.ready, (k % 2 == 0));
         if (bus0.ready) begin
            pulses++;
            if (pulses == 65535) check("w0 writecount FFFE", bus0.writecount, 16'hFFFE);
            if (pulses == 65537) check("w0 writecount sat",  bus0.writecount, 16'hFFFF);
         end
      end
      check("w0 pulses", pulses, 65540);
      bus0.memwrite = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("w0 writecount final", bus0.writecount, 16'hFFFF);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Synthesizable data-memory responder on the CPU data port (memwrite/dataadr/writedata).
- Serves reads and writes with a programmable wait-state handshake.
- Counts committed writes.
- Detects a pass/fail signature store, so the self-checking test programs can run on hardware without a simulation checker.
- Sits between the core's data port and top-level status pins.

Parameters:
ADDR_W, 8, word-index width; memory depth = 2^ADDR_W 32-bit words
WAIT_CYCLES, 2, extra cycles between request acceptance and ready (0..15)
SIG_ADR, 32'h00000054, byte address of the signature store
SIG_DATA, 32'h00000007, value that signals pass when stored to SIG_ADR

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-low reset
memwrite  input  1  write request; held by the CPU until ready
memread  input  1  read request; held by the CPU until ready
dataadr  input  32  byte address
writedata  input  32  store data
readdata  output  32  load data, valid while ready=1
ready  output  1  one-cycle completion strobe
misaligned_err  output  1  sticky: an access had dataadr[1:0]!=0
done  output  1  sticky: a store to SIG_ADR occurred
pass  output  1  sticky: that store carried SIG_DATA
writecount  output  16  committed-write count, saturating

Behaviour:
- Reset (reset==0 at a rising edge):
  - Outputs: readdata=0, ready=0, misaligned_err=0, done=0, pass=0, writecount=0.
  - FSM goes to IDLE.
  - RAM contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If memwrite|memread, capture dataadr, writedata and the op (memwrite has priority if both are high), then go to WAIT.
  - If WAIT_CYCLES==0, go straight to RESP.
- WAIT:
  - A 4-bit counter counts WAIT_CYCLES cycles, then the FSM goes to RESP.
  - Input changes during WAIT are ignored; the captured values are used.
- RESP: ready=1 for exactly one cycle, then return to IDLE.
- Latency: with a request sampled at edge N, ready is high during cycle N+1+WAIT_CYCLES.
  - The CPU drops its request after seeing ready.
  - IDLE re-samples at the next edge, so back-to-back requests have one idle cycle between ready pulses.
- Word index = captured dataadr[ADDR_W+1:2]. Upper address bits are ignored, so addresses alias by wrap-around modulo 4*2^ADDR_W.
- Write, in the RESP cycle:
  - RAM[index] <= writedata.
  - writecount increments, saturating at 16'hFFFF (no wrap).
- Read: readdata = RAM[index] during RESP. readdata holds its last value outside RESP and is not guaranteed valid there.
- Misaligned access (captured dataadr[1:0]!=0):
  - Still completes with ready.
  - Write is suppressed and not counted; read returns 0.
  - misaligned_err is set.
- Signature detection, on a committed aligned write with full 32-bit address == SIG_ADR:
  - done=1.
  - pass=1 only if writedata==SIG_DATA.
  - Only the first such store decides pass; later stores do not change pass or done.
  - Signature address aliases (differing upper bits) do not trigger detection but do write RAM.
- Read-after-write to the same address returns the new data (the write commits in an earlier RESP).
- Reset mid-transaction (in WAIT or RESP): the transaction is abandoned, no write commits, ready deasserts at the next cycle.

Test Plan:
- WAIT_CYCLES=2: write 32'hDEADBEEF to 0x10 at edge 0 -> ready high only in cycle 3, writecount=1; then read 0x10 -> readdata=32'hDEADBEEF with ready.
- Store 7 to 0x54 -> done=1, pass=1. Then store 9 to 0x54 -> done=1, pass stays 1, writecount=2.
- Store 21 to 0x54 as the first signature store -> done=1, pass=0. Also check that address 0x10000054 (ADDR_W=8) writes RAM[21] but leaves done=0.
- Write to 0x12 -> ready pulses, misaligned_err=1, writecount unchanged, RAM[4] unchanged; read 0x13 -> readdata=0.
- memwrite and memread both high -> write performed; drop reset to 0 during WAIT -> no commit, all outputs 0 next cycle, RAM[index] retains its old value.
- WAIT_CYCLES=0: 70000 back-to-back writes -> ready every 2nd cycle, writecount saturates at 16'hFFFF.
